// File: rtl/i2s_pkg.sv
// Shared types, default geometry and the slot-position helper for the I2S
// stream controller.
package i2s_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Default geometry; the modules take these as parameter defaults
    localparam int DEF_MCLK_PER_SCLK = 4;
    localparam int DEF_DATA_W        = 24;
    localparam int DEF_SLOT_W        = 32;
    localparam int FRAME_BITS        = 2 * DEF_SLOT_W;
    localparam int HALF_DIV          = DEF_MCLK_PER_SCLK / 2;

    // idx is 8 bits wide, which covers any sample width up to 255 bits
    typedef struct packed {
        logic       valid;
        logic [7:0] idx;
    } slot_bit_t;

    // Maps a position within a channel slot to the sample bit carried there.
    // Position 0 is the one-bit I2S delay; positions past the sample are padding.
    function automatic slot_bit_t slot_bit_idx(input int unsigned p, input int unsigned data_w);
        slot_bit_t r;
        r.valid = 1'b0;
        r.idx   = '0;
        if ((p >= 1) && (p <= data_w)) begin
            r.valid = 1'b1;
            r.idx   = 8'(data_w - p);
        end
        return r;
    endfunction

endpackage

// File: rtl/i2s_bit_timer.sv
// Bit-clock generator: divides mclk into sclk, counts bit periods across a
// stereo frame, drives lrclk and produces single-cycle timing strobes.
module i2s_bit_timer
    import i2s_pkg::*;
#(
    parameter int  MCLK_PER_SCLK = DEF_MCLK_PER_SCLK,
    parameter int  SLOT_W        = DEF_SLOT_W,
    localparam int DIV_W         = $clog2(MCLK_PER_SCLK),
    localparam int BIT_W         = $clog2(2 * SLOT_W)
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic             run,
    output logic [BIT_W-1:0] bit_cnt,
    output logic             sclk,
    output logic             lrclk,
    output logic             rise_evt,
    output logic             fall_evt,
    output logic             frame_start,
    output logic             frame_last,
    output logic             frame_prelast
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCLK_PER_SCLK - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(MCLK_PER_SCLK - 2);
    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(MCLK_PER_SCLK / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(MCLK_PER_SCLK / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] BIT_SLOT = BIT_W'(SLOT_W);

    logic [DIV_W-1:0] div_cnt;

    // Counters sit at zero while idle so every run begins at the top of a frame
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (!run) begin
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign sclk          = (div_cnt >= DIV_HALF);
    assign lrclk         = (bit_cnt >= BIT_SLOT);
    assign rise_evt      = run && (div_cnt == DIV_RISE);
    assign fall_evt      = run && (div_cnt == DIV_LAST);
    assign frame_start   = run && (div_cnt == '0) && (bit_cnt == '0);
    assign frame_last    = fall_evt && (bit_cnt == BIT_LAST);
    assign frame_prelast = run && (div_cnt == DIV_PRE) && (bit_cnt == BIT_LAST);

endmodule

// File: rtl/i2s_stream_controller.sv
// Master-mode I2S frame sequencer: serialises DAC pairs onto sdout, gathers
// ADC pairs from sdin and trades samples with the DSP via valid/ready.
// Optional build macro I2S_UNDERRUN_CNT_EN adds a saturating underrun counter.
module i2s_stream_controller
    import i2s_pkg::*;
#(
    parameter int MCLK_PER_SCLK = DEF_MCLK_PER_SCLK,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int SLOT_W        = DEF_SLOT_W
) (
    input  logic              mclk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] tx_left,
    input  logic [DATA_W-1:0] tx_right,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_left,
    output logic [DATA_W-1:0] rx_right,
    output logic              rx_valid,
    input  logic              sdin,
    output logic              sdout,
    output logic              sclk,
    output logic              lrclk,
    output logic              busy,
    output logic              underrun
`ifdef I2S_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_cnt
`endif
);

    localparam int               BIT_W    = $clog2(2 * SLOT_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] BIT_SLOT = BIT_W'(SLOT_W);

    state_t            state;
    logic              run;
    logic [BIT_W-1:0]  bit_cnt;
    logic              rise_evt, fall_evt, frame_start, frame_last, frame_prelast;

    logic              hold_full;
    logic [DATA_W-1:0] hold_l, hold_r;
    logic [DATA_W-1:0] tx_word_l, tx_word_r;
    logic [DATA_W-1:0] rx_sh_l, rx_sh_r, rx_next_l, rx_next_r, rx_mask;
    logic              accept;

    logic [BIT_W-1:0]  next_bit;
    logic              next_right, rx_right_slot, tx_bit;
    logic [DATA_W-1:0] tx_word;
    slot_bit_t         tx_sel, rx_sel;

    assign run      = (state == RUN);
    assign busy     = run;
    assign tx_ready = ~hold_full;
    assign accept   = tx_valid && tx_ready;

    i2s_bit_timer #(
        .MCLK_PER_SCLK (MCLK_PER_SCLK),
        .SLOT_W        (SLOT_W)
    ) u_timer (
        .mclk          (mclk),
        .rst_n         (rst_n),
        .run           (run),
        .bit_cnt       (bit_cnt),
        .sclk          (sclk),
        .lrclk         (lrclk),
        .rise_evt      (rise_evt),
        .fall_evt      (fall_evt),
        .frame_start   (frame_start),
        .frame_last    (frame_last),
        .frame_prelast (frame_prelast)
    );

    // Run/stop control; a stop request only takes effect at a frame boundary
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (en) state <= RUN;
                RUN:     if (frame_last && !en) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bit selection: the outgoing bit belongs to the period starting at the
    // next fall event, the incoming bit to the current period
    always_comb begin
        next_bit      = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        next_right    = (next_bit >= BIT_SLOT);
        tx_sel        = slot_bit_idx(next_right ? 32'(next_bit) - 32'(SLOT_W) : 32'(next_bit), DATA_W);
        tx_word       = next_right ? tx_word_r : tx_word_l;
        tx_bit        = 1'b0;
        rx_right_slot = (bit_cnt >= BIT_SLOT);
        rx_sel        = slot_bit_idx(rx_right_slot ? 32'(bit_cnt) - 32'(SLOT_W) : 32'(bit_cnt), DATA_W);
        rx_mask       = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (tx_sel.valid && (tx_sel.idx == 8'(i))) tx_bit = tx_word[i];
            rx_mask[i] = rx_sel.valid && (rx_sel.idx == 8'(i));
        end
        rx_next_l = rx_sh_l;
        rx_next_r = rx_sh_r;
        if (rise_evt) begin
            if (rx_right_slot) rx_next_r = (rx_sh_r & ~rx_mask) | (rx_mask & {DATA_W{sdin}});
            else               rx_next_l = (rx_sh_l & ~rx_mask) | (rx_mask & {DATA_W{sdin}});
        end
    end

    // Holding register handshake and frame-start transfer; an empty holding
    // register at frame start sends silence and flags an underrun
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
            tx_word_l <= '0;
            tx_word_r <= '0;
            underrun  <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (frame_start) begin
                if (hold_full) begin
                    tx_word_l <= hold_l;
                    tx_word_r <= hold_r;
                    hold_full <= 1'b0;
                end else begin
                    tx_word_l <= '0;
                    tx_word_r <= '0;
                    underrun  <= 1'b1;
                end
            end
            if (accept) begin
                hold_l    <= tx_left;
                hold_r    <= tx_right;
                hold_full <= 1'b1;
            end
        end
    end

    // Serial output updates on sclk falling edges and is forced low when idle
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            sdout <= 1'b0;
        end else if (!run) begin
            sdout <= 1'b0;
        end else if (fall_evt) begin
            sdout <= tx_bit;
        end
    end

    // Capture sdin on rising edges and publish the pair so rx_valid is high
    // during the final mclk of the frame
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sh_l  <= '0;
            rx_sh_r  <= '0;
            rx_left  <= '0;
            rx_right <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_sh_l  <= rx_next_l;
            rx_sh_r  <= rx_next_r;
            rx_valid <= 1'b0;
            if (frame_prelast) begin
                rx_left  <= rx_next_l;
                rx_right <= rx_next_r;
                rx_valid <= 1'b1;
            end
        end
    end

`ifdef I2S_UNDERRUN_CNT_EN
    // Saturating count of underrun events, cleared only by reset
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= '0;
        end else if (frame_start && !hold_full && (underrun_cnt != 16'hFFFF)) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_stream_controller.sv
// Directed bench for i2s_stream_controller (MCLK_PER_SCLK=4, DATA_W=24,
// SLOT_W=32, 256 mclk per frame). Honours I2S_UNDERRUN_CNT_EN when defined.
module tb_i2s_stream_controller;

    logic        mclk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [23:0] tx_left, tx_right;
    logic        tx_valid;
    logic        tx_ready;
    logic [23:0] rx_left, rx_right;
    logic        rx_valid;
    logic        sdin;
    logic        sdout, sclk, lrclk, busy, underrun;
    logic        loopback;
`ifdef I2S_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    assign sdin = loopback ? sdout : 1'b0;

    always #5 mclk = ~mclk;

    i2s_stream_controller #(
        .MCLK_PER_SCLK (4),
        .DATA_W        (24),
        .SLOT_W        (32)
    ) dut (
        .mclk     (mclk),
        .rst_n    (rst_n),
        .en       (en),
        .tx_left  (tx_left),
        .tx_right (tx_right),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_left  (rx_left),
        .rx_right (rx_right),
        .rx_valid (rx_valid),
        .sdin     (sdin),
        .sdout    (sdout),
        .sclk     (sclk),
        .lrclk    (lrclk),
        .busy     (busy),
        .underrun (underrun)
`ifdef I2S_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    // Expected 64-bit frame as seen on sdout, bit index = bit period number
    function automatic logic [63:0] make_frame(input logic [23:0] l, input logic [23:0] r);
        logic [63:0] f;
        f = '0;
        for (int p = 1; p <= 24; p++) begin
            f[6'(p)]      = l[5'(24 - p)];
            f[6'(32 + p)] = r[5'(24 - p)];
        end
        return f;
    endfunction

    task automatic do_reset();
        @(negedge mclk);
        rst_n    = 1'b0;
        en       = 1'b0;
        tx_valid = 1'b0;
        repeat (2) @(negedge mclk);
        rst_n = 1'b1;
    endtask

    task automatic preload(input logic [23:0] l, input logic [23:0] r);
        tx_left  = l;
        tx_right = r;
        tx_valid = 1'b1;
        @(negedge mclk);
        tx_valid = 1'b0;
    endtask

    // Observes one frame from cycle start_c (next negedge) through cycle 255
    task automatic capture_frame(input int start_c, input int en_drop_c, input logic do_push,
                                 input logic [23:0] pl, input logic [23:0] pr,
                                 output logic [63:0] bits, output int rxv_n, output int rxv_c,
                                 output logic [23:0] rl, output logic [23:0] rr,
                                 output int und_n, output int und_c, output int rise_c,
                                 output int lr_c, output logic busy_end);
        bits = '0; rxv_n = 0; rxv_c = -1; rl = '0; rr = '0;
        und_n = 0; und_c = -1; rise_c = -1; lr_c = -1; busy_end = 1'b0;
        for (int c = start_c; c < 256; c++) begin
            @(negedge mclk);
            if ((c % 4) == 2) bits[6'(c / 4)] = sdout;
            if (rx_valid) begin rxv_n++; rxv_c = c; rl = rx_left; rr = rx_right; end
            if (underrun) begin und_n++; und_c = c; end
            if (sclk && (rise_c < 0)) rise_c = c;
            if (lrclk && (lr_c < 0)) lr_c = c;
            if (do_push && (c == 8)) begin tx_left = pl; tx_right = pr; tx_valid = 1'b1; end
            if (do_push && (c == 9)) tx_valid = 1'b0;
            if (c == en_drop_c) en = 1'b0;
            if (c == 255) busy_end = busy;
        end
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0; en = 1'b1; tx_valid = 1'b0; tx_left = '0; tx_right = '0; loopback = 1'b0;
        repeat (3) @(negedge mclk);
        checks++; if (sclk !== 1'b0)     begin failures++; $display("[TB] FAIL rst_sclk got=%0h exp=0", sclk); end
        checks++; if (lrclk !== 1'b0)    begin failures++; $display("[TB] FAIL rst_lrclk got=%0h exp=0", lrclk); end
        checks++; if (sdout !== 1'b0)    begin failures++; $display("[TB] FAIL rst_sdout got=%0h exp=0", sdout); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("[TB] FAIL rst_busy got=%0h exp=0", busy); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_rx_valid got=%0h exp=0", rx_valid); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("[TB] FAIL rst_underrun got=%0h exp=0", underrun); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_tx_ready got=%0h exp=1", tx_ready); end
        checks++; if ({rx_left, rx_right} !== 48'h0) begin failures++; $display("[TB] FAIL rst_rx_data got=%h exp=0", {rx_left, rx_right}); end
`ifdef I2S_UNDERRUN_CNT_EN
        checks++; if (underrun_cnt !== 16'h0) begin failures++; $display("[TB] FAIL rst_underrun_cnt got=%h exp=0", underrun_cnt); end
`endif
        en    = 1'b0;
        rst_n = 1'b1;
        bad   = 0;
        repeat (1000) begin
            @(negedge mclk);
            if ((sclk !== 1'b0) || (lrclk !== 1'b0) || (busy !== 1'b0)) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("[TB] FAIL idle_clocks got=%0d active cycles exp=0", bad); end
    endtask

    task automatic test_tx_decode();
        logic [63:0] bits; int rxv_n, rxv_c, und_n, und_c, rise_c, lr_c;
        logic [23:0] rl, rr; logic busy_end;
        do_reset();
        tx_left = 24'hA5A5A5; tx_right = 24'h5A5A5A; tx_valid = 1'b1;
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL t2_ready_pre got=%0h exp=1", tx_ready); end
        @(negedge mclk);
        tx_valid = 1'b0;
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("[TB] FAIL t2_ready_accept got=%0h exp=0", tx_ready); end
        en = 1'b1;
        @(negedge mclk);
        checks++; if (busy !== 1'b1)     begin failures++; $display("[TB] FAIL t2_busy_c0 got=%0h exp=1", busy); end
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("[TB] FAIL t2_ready_c0 got=%0h exp=0", tx_ready); end
        @(negedge mclk);
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL t2_ready_c1 got=%0h exp=1", tx_ready); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("[TB] FAIL t2_underrun_c1 got=%0h exp=0", underrun); end
        capture_frame(2, 255, 1'b0, 24'h0, 24'h0, bits, rxv_n, rxv_c, rl, rr, und_n, und_c, rise_c, lr_c, busy_end);
        checks++; if (bits !== make_frame(24'hA5A5A5, 24'h5A5A5A)) begin failures++; $display("[TB] FAIL t2_sdout_frame got=%h exp=%h", bits, make_frame(24'hA5A5A5, 24'h5A5A5A)); end
        checks++; if (rise_c != 2)   begin failures++; $display("[TB] FAIL t2_first_rise got=%0d exp=2", rise_c); end
        checks++; if (lr_c != 128)   begin failures++; $display("[TB] FAIL t2_lrclk_rise got=%0d exp=128", lr_c); end
        checks++; if (rxv_c != 255)  begin failures++; $display("[TB] FAIL t2_rx_valid_pos got=%0d exp=255", rxv_c); end
    endtask

    task automatic test_loopback();
        logic [23:0] pl [4] = '{24'h800001, 24'h123456, 24'hFFFFFF, 24'hC0FFEE};
        logic [23:0] pr [4] = '{24'h7FFFFE, 24'hABCDEF, 24'h000000, 24'h0BADF0};
        logic [63:0] bits; int rxv_n, rxv_c, und_n, und_c, rise_c, lr_c;
        logic [23:0] rl, rr; logic busy_end;
        do_reset();
        loopback = 1'b1;
        preload(pl[0], pr[0]);
        en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            capture_frame(0, (f == 2) ? 255 : -1, 1'b1, pl[f+1], pr[f+1],
                          bits, rxv_n, rxv_c, rl, rr, und_n, und_c, rise_c, lr_c, busy_end);
            checks++; if (bits !== make_frame(pl[f], pr[f])) begin failures++; $display("[TB] FAIL t3_sdout_f%0d got=%h exp=%h", f, bits, make_frame(pl[f], pr[f])); end
            checks++; if ((rxv_n != 1) || (rxv_c != 255)) begin failures++; $display("[TB] FAIL t3_rx_valid_f%0d got=n%0d@%0d exp=n1@255", f, rxv_n, rxv_c); end
            checks++; if ({rl, rr} !== {pl[f], pr[f]}) begin failures++; $display("[TB] FAIL t3_rx_pair_f%0d got=%h exp=%h", f, {rl, rr}, {pl[f], pr[f]}); end
            checks++; if (und_n != 0) begin failures++; $display("[TB] FAIL t3_underrun_f%0d got=%0d exp=0", f, und_n); end
        end
    endtask

    task automatic test_underrun();
        logic [63:0] bits; int rxv_n, rxv_c, und_n, und_c, rise_c, lr_c;
        logic [23:0] rl, rr; logic busy_end;
        do_reset();
        loopback = 1'b0;
        en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            capture_frame(0, (f == 2) ? 255 : -1, 1'b0, 24'h0, 24'h0,
                          bits, rxv_n, rxv_c, rl, rr, und_n, und_c, rise_c, lr_c, busy_end);
            checks++; if (bits !== 64'h0) begin failures++; $display("[TB] FAIL t4_sdout_f%0d got=%h exp=0", f, bits); end
            checks++; if ((und_n != 1) || (und_c != 1)) begin failures++; $display("[TB] FAIL t4_underrun_f%0d got=n%0d@%0d exp=n1@1", f, und_n, und_c); end
        end
`ifdef I2S_UNDERRUN_CNT_EN
        checks++; if (underrun_cnt !== 16'd3) begin failures++; $display("[TB] FAIL t4_underrun_cnt got=%0d exp=3", underrun_cnt); end
`endif
    endtask

    task automatic test_stop();
        logic [63:0] bits; int rxv_n, rxv_c, und_n, und_c, rise_c, lr_c, bad;
        logic [23:0] rl, rr; logic busy_end;
        do_reset();
        loopback = 1'b1;
        preload(24'h3C3C3C, 24'hC3C3C3);
        en = 1'b1;
        capture_frame(0, 40, 1'b0, 24'h0, 24'h0, bits, rxv_n, rxv_c, rl, rr, und_n, und_c, rise_c, lr_c, busy_end);
        checks++; if (busy_end !== 1'b1) begin failures++; $display("[TB] FAIL t5_busy_c255 got=%0h exp=1", busy_end); end
        checks++; if ((rxv_n != 1) || (rxv_c != 255)) begin failures++; $display("[TB] FAIL t5_final_rx_valid got=n%0d@%0d exp=n1@255", rxv_n, rxv_c); end
        checks++; if ({rl, rr} !== 48'h3C3C3CC3C3C3) begin failures++; $display("[TB] FAIL t5_rx_pair got=%h exp=3c3c3cc3c3c3", {rl, rr}); end
        checks++; if (bits !== make_frame(24'h3C3C3C, 24'hC3C3C3)) begin failures++; $display("[TB] FAIL t5_sdout_frame got=%h", bits); end
        @(negedge mclk);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL t5_busy_after got=%0h exp=0", busy); end
        bad = 0;
        repeat (300) begin
            @(negedge mclk);
            if (rx_valid || sclk || lrclk || sdout || busy) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("[TB] FAIL t5_idle_quiet got=%0d active cycles exp=0", bad); end
    endtask

    task automatic test_mid_reset();
        logic [63:0] bits; int rxv_n, rxv_c, und_n, und_c, rise_c, lr_c, bad;
        logic [23:0] rl, rr; logic busy_end;
        do_reset();
        loopback = 1'b1;
        preload(24'h123456, 24'h7F0001);
        en = 1'b1;
        for (int c = 0; c <= 160; c++) begin
            @(negedge mclk);
            if (c == 100) begin tx_left = 24'hDEAD01; tx_right = 24'hBEEF02; tx_valid = 1'b1; end
            if (c == 101) tx_valid = 1'b0;
        end
        checks++; if ({lrclk, sdout, tx_ready} !== 3'b110) begin failures++; $display("[TB] FAIL t6_pre_reset got=%b exp=110", {lrclk, sdout, tx_ready}); end
        rst_n = 1'b0;
        #1;
        checks++; if ({sclk, lrclk, sdout, busy, rx_valid, underrun} !== 6'b0) begin failures++; $display("[TB] FAIL t6_outputs_cleared got=%b exp=000000", {sclk, lrclk, sdout, busy, rx_valid, underrun}); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("[TB] FAIL t6_tx_ready got=%0h exp=1", tx_ready); end
        bad = 0;
        repeat (20) begin
            @(negedge mclk);
            if (rx_valid || busy) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("[TB] FAIL t6_no_publish got=%0d exp=0", bad); end
        rst_n = 1'b1;
        capture_frame(0, 255, 1'b0, 24'h0, 24'h0, bits, rxv_n, rxv_c, rl, rr, und_n, und_c, rise_c, lr_c, busy_end);
        checks++; if ((und_n != 1) || (und_c != 1)) begin failures++; $display("[TB] FAIL t6_underrun got=n%0d@%0d exp=n1@1", und_n, und_c); end
        checks++; if (bits !== 64'h0) begin failures++; $display("[TB] FAIL t6_sdout got=%h exp=0", bits); end
        checks++; if (rise_c != 2) begin failures++; $display("[TB] FAIL t6_first_rise got=%0d exp=2", rise_c); end
        checks++; if ((rxv_c != 255) || ({rl, rr} !== 48'h0)) begin failures++; $display("[TB] FAIL t6_rx got=%h@%0d exp=0@255", {rl, rr}, rxv_c); end
    endtask

    initial begin
        test_reset();
        test_tx_decode();
        test_loopback();
        test_underrun();
        test_stop();
        test_mid_reset();
        repeat (4) @(negedge mclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
